// File: rtl/npc_seq_pkg.sv
// -----------------------------------------------------------------------------
// npc_seq_pkg
// Shared definitions for the CADR4 micro-PC sequencer:
//   PC_W / SPC_W / SPC_DEPTH  micro-PC width, SPC entry width, return-stack depth
//   PTR_W / CNT_W             stack pointer width and occupancy-count width
//   TRAP_VEC                  micro-PC forced on a trap
//   npc_src_e                 next-PC source select
//   stk_op_t, resolve_op()    push/pop request derived from call/ret bits
//   ret_entry()               builds a stack entry from a return address
// -----------------------------------------------------------------------------
package npc_seq_pkg;

  localparam int PC_W      = 14;
  localparam int SPC_W     = 19;
  localparam int SPC_DEPTH = 32;
  localparam int PTR_W     = $clog2(SPC_DEPTH);
  // One extra bit so the count can hold SPC_DEPTH itself.
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [PC_W-1:0] TRAP_VEC = '0;

  typedef enum logic [1:0] {
    SRC_TRAP,
    SRC_DISP,
    SRC_JUMP,
    SRC_SEQ
  } npc_src_e;

  typedef struct packed {
    logic push;
    logic pop;
  } stk_op_t;

  // When call and ret are both set, the return wins and no push happens.
  function automatic stk_op_t resolve_op(input logic call, input logic ret);
    stk_op_t op;
    op.pop  = ret;
    op.push = call & ~ret;
    return op;
  endfunction

  // Return addresses are stored zero-extended; the upper bits are flag space.
  function automatic logic [SPC_W-1:0] ret_entry(input logic [PC_W-1:0] addr);
    return {{(SPC_W-PC_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/npc_seq_if.sv
// -----------------------------------------------------------------------------
// npc_seq_if
// Bundles the sequencer's control inputs and status outputs.
//   master : drives fetch/trap/dispatch/jump/external-SPC controls,
//            observes pc, ipc, spc_top, spcptr, lpc_hold and sticky flags
//   slave  : the sequencer side (npc_seq)
// -----------------------------------------------------------------------------
interface npc_seq_if;
  import npc_seq_pkg::*;

  logic             state_fetch;
  logic             trap;
  logic             disp_en;
  logic [PC_W-1:0]  disp_addr;
  logic             disp_call;
  logic             disp_ret;
  logic             jump_en;
  logic             jcond;
  logic [PC_W-1:0]  jump_addr;
  logic             jump_call;
  logic             jump_ret;
  logic             spc_wr;
  logic [SPC_W-1:0] spc_wdata;
  logic             spc_rd;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  ipc;
  logic [SPC_W-1:0] spc_top;
  logic [PTR_W-1:0] spcptr;
  logic             lpc_hold;
  logic             spc_ovf;
  logic             spc_unf;
  logic             spc_conflict;

  modport master (
    output state_fetch, trap,
    output disp_en, disp_addr, disp_call, disp_ret,
    output jump_en, jcond, jump_addr, jump_call, jump_ret,
    output spc_wr, spc_wdata, spc_rd,
    input  pc, ipc, spc_top, spcptr, lpc_hold,
    input  spc_ovf, spc_unf, spc_conflict
  );

  modport slave (
    input  state_fetch, trap,
    input  disp_en, disp_addr, disp_call, disp_ret,
    input  jump_en, jcond, jump_addr, jump_call, jump_ret,
    input  spc_wr, spc_wdata, spc_rd,
    output pc, ipc, spc_top, spcptr, lpc_hold,
    output spc_ovf, spc_unf, spc_conflict
  );

endinterface

// File: rtl/npc_seq_spc_stack.sv
// -----------------------------------------------------------------------------
// npc_seq_spc_stack
// Circular SPC return stack with pointer, occupancy count and sticky
// overflow/underflow/conflict flags.
//   clk, reset             clock, synchronous active-high reset
//   i_int_push/i_int_pop   sequencer stack op (already qualified by fetch)
//   i_int_data             entry pushed by the sequencer
//   i_ext_wr/i_ext_rd      external push/pop, any clock
//   i_ext_data             entry pushed by an external write
//   o_top                  mem[ptr] when non-empty, else 0
//   o_ptr                  stack pointer
//   o_ovf/o_unf/o_conflict sticky flags, cleared only by reset
// The RAM itself is never cleared.
// -----------------------------------------------------------------------------
module npc_seq_spc_stack
  import npc_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_int_push,
  input  logic             i_int_pop,
  input  logic [SPC_W-1:0] i_int_data,
  input  logic             i_ext_wr,
  input  logic             i_ext_rd,
  input  logic [SPC_W-1:0] i_ext_data,
  output logic [SPC_W-1:0] o_top,
  output logic [PTR_W-1:0] o_ptr,
  output logic             o_ovf,
  output logic             o_unf,
  output logic             o_conflict
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SPC_DEPTH);

  logic [SPC_W-1:0] r_mem [SPC_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic             r_conflict;

  logic             w_int_op;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [SPC_W-1:0] w_data;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_ptr_dec;

  // The sequencer owns the stack whenever it has an op; an external op
  // landing on the same edge is discarded and flagged. Between the two
  // external requests, the write takes precedence.
  assign w_int_op  = i_int_push | i_int_pop;
  assign w_push    = i_int_push | (~w_int_op & i_ext_wr);
  assign w_pop     = i_int_pop  | (~w_int_op & ~i_ext_wr & i_ext_rd);
  assign w_drop    = w_int_op & (i_ext_wr | i_ext_rd);
  assign w_data    = w_int_op ? i_int_data : i_ext_data;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_ptr_dec = r_ptr - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_drop)
        r_conflict <= 1'b1;
      if (w_push) begin
        r_ptr <= w_ptr_inc;
        // A full stack wraps onto its oldest entry; count stays pinned.
        if (r_cnt == CNT_FULL)
          r_ovf <= 1'b1;
        else
          r_cnt <= r_cnt + 1'b1;
      end else if (w_pop) begin
        // The pointer moves even when empty so it tracks the pop history.
        r_ptr <= w_ptr_dec;
        if (r_cnt == '0)
          r_unf <= 1'b1;
        else
          r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push)
      r_mem[w_ptr_inc] <= w_data;
  end

  assign o_top      = (r_cnt != '0) ? r_mem[r_ptr] : '0;
  assign o_ptr      = r_ptr;
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/npc_seq.sv
// -----------------------------------------------------------------------------
// npc_seq
// Microcode next-PC sequencer for the CADR4 control path. On each
// state_fetch it picks the next micro-PC from trap, dispatch, taken jump or
// sequential increment, drives call/return ops into the SPC stack and
// generates lpc_hold for the last-PC register.
//   clk, reset   clock, synchronous active-high reset
//   bus (slave)  fetch/trap/dispatch/jump/external-SPC inputs;
//                pc, ipc, spc_top, spcptr, lpc_hold, sticky flags out
// -----------------------------------------------------------------------------
module npc_seq
  import npc_seq_pkg::*;
(
  input logic        clk,
  input logic        reset,
  npc_seq_if.slave   bus
);

  logic [PC_W-1:0]  r_pc;
  logic             r_lpc_hold;

  logic [PC_W-1:0]  w_ipc;
  logic [PC_W-1:0]  w_npc;
  npc_src_e         w_src;
  stk_op_t          w_op;
  logic [SPC_W-1:0] w_spc_top;
  logic [PTR_W-1:0] w_spcptr;
  logic             w_ovf;
  logic             w_unf;
  logic             w_conflict;

  // Wraps 14'h3FFF -> 0 by truncation.
  assign w_ipc = r_pc + 1'b1;

  always_comb begin
    w_src = SRC_SEQ;
    if (bus.trap)
      w_src = SRC_TRAP;
    else if (bus.disp_en)
      w_src = SRC_DISP;
    else if (bus.jump_en && bus.jcond)
      w_src = SRC_JUMP;
  end

  // Returns take their target from the current stack top, i.e. before the
  // pop that accompanies them. A not-taken jump falls to SRC_SEQ, so its
  // call/ret bits never reach the stack.
  always_comb begin
    w_npc = w_ipc;
    w_op  = '0;
    case (w_src)
      SRC_TRAP: w_npc = TRAP_VEC;
      SRC_DISP: begin
        w_npc = bus.disp_ret ? w_spc_top[PC_W-1:0] : bus.disp_addr;
        w_op  = resolve_op(bus.disp_call, bus.disp_ret);
      end
      SRC_JUMP: begin
        w_npc = bus.jump_ret ? w_spc_top[PC_W-1:0] : bus.jump_addr;
        w_op  = resolve_op(bus.jump_call, bus.jump_ret);
      end
      default:  w_npc = w_ipc;
    endcase
  end

  // lpc_hold is high for exactly the fetch interval following a trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= TRAP_VEC;
      r_lpc_hold <= 1'b0;
    end else if (bus.state_fetch) begin
      r_pc       <= w_npc;
      r_lpc_hold <= (w_src == SRC_TRAP);
    end
  end

  npc_seq_spc_stack u_stack (
    .clk        (clk),
    .reset      (reset),
    .i_int_push (bus.state_fetch & w_op.push),
    .i_int_pop  (bus.state_fetch & w_op.pop),
    .i_int_data (ret_entry(w_ipc)),
    .i_ext_wr   (bus.spc_wr),
    .i_ext_rd   (bus.spc_rd),
    .i_ext_data (bus.spc_wdata),
    .o_top      (w_spc_top),
    .o_ptr      (w_spcptr),
    .o_ovf      (w_ovf),
    .o_unf      (w_unf),
    .o_conflict (w_conflict)
  );

  assign bus.pc           = r_pc;
  assign bus.ipc          = w_ipc;
  assign bus.spc_top      = w_spc_top;
  assign bus.spcptr       = w_spcptr;
  assign bus.lpc_hold     = r_lpc_hold;
  assign bus.spc_ovf      = w_ovf;
  assign bus.spc_unf      = w_unf;
  assign bus.spc_conflict = w_conflict;

endmodule

// File: tb/tb_npc_seq.sv
// -----------------------------------------------------------------------------
// tb_npc_seq
// Scoreboard bench for npc_seq: each test pushes the expected post-edge state
// when it drives a cycle, then pops and compares it once the edge is past.
// -----------------------------------------------------------------------------
module tb_npc_seq;
  import npc_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  npc_seq_if ifc();

  npc_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] pc;
    logic [13:0] ipc;
    logic [4:0]  ptr;
    logic        lpc;
    logic [18:0] top;
    logic        ovf;
    logic        unf;
    logic        conf;
  } exp_t;

  exp_t q[$];
  exp_t e, o;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic [13:0] pc, input logic [4:0] ptr,
                              input logic lpc, input logic [18:0] top,
                              input logic ovf, input logic unf, input logic conf);
    exp_t x;
    x.pc   = pc;
    x.ipc  = 14'(pc + 14'd1);
    x.ptr  = ptr;
    x.lpc  = lpc;
    x.top  = top;
    x.ovf  = ovf;
    x.unf  = unf;
    x.conf = conf;
    return x;
  endfunction

  function automatic exp_t observe();
    exp_t x;
    x.pc   = ifc.pc;
    x.ipc  = ifc.ipc;
    x.ptr  = ifc.spcptr;
    x.lpc  = ifc.lpc_hold;
    x.top  = ifc.spc_top;
    x.ovf  = ifc.spc_ovf;
    x.unf  = ifc.spc_unf;
    x.conf = ifc.spc_conflict;
    return x;
  endfunction

  task automatic idle();
    ifc.state_fetch = 1'b0; ifc.trap = 1'b0;
    ifc.disp_en = 1'b0; ifc.disp_addr = '0; ifc.disp_call = 1'b0; ifc.disp_ret = 1'b0;
    ifc.jump_en = 1'b0; ifc.jcond = 1'b0; ifc.jump_addr = '0;
    ifc.jump_call = 1'b0; ifc.jump_ret = 1'b0;
    ifc.spc_wr = 1'b0; ifc.spc_wdata = '0; ifc.spc_rd = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Reset must win over a fetch with a taken jump-call and an external write.
    idle();
    reset = 1'b1;
    ifc.state_fetch = 1'b1; ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_call = 1'b1;
    ifc.jump_addr = 14'h0055; ifc.spc_wr = 1'b1; ifc.spc_wdata = 19'h1234;
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk(14'h0, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL reset[%0d]: got %p want %p", i, o, e); end
    end
    reset = 1'b0;
    idle();
    // No fetch: pc holds.
    q.push_back(mk(14'h0, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL reset_hold: got %p want %p", o, e); end
  endtask

  task automatic test_seq();
    idle();
    ifc.state_fetch = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      q.push_back(mk(14'(i), 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL seq[%0d]: got %p want %p", i, o, e); end
    end
    // Without state_fetch even a trap must not move pc or lpc_hold.
    idle();
    ifc.trap = 1'b1;
    q.push_back(mk(14'h3, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL seq_nofetch: got %p want %p", o, e); end
  endtask

  task automatic test_call_ret();
    exp_t exps[6];
    exps[0] = mk(14'h0100, 5'd0, 1'b0, 19'h0,     1'b0, 1'b0, 1'b0);
    exps[1] = mk(14'h2000, 5'd1, 1'b0, 19'h00101, 1'b0, 1'b0, 1'b0);
    exps[2] = mk(14'h2001, 5'd1, 1'b0, 19'h00101, 1'b0, 1'b0, 1'b0);
    exps[3] = mk(14'h0101, 5'd0, 1'b0, 19'h0,     1'b0, 1'b0, 1'b0);
    exps[4] = mk(14'h0300, 5'd1, 1'b0, 19'h00102, 1'b0, 1'b0, 1'b0);
    exps[5] = mk(14'h0102, 5'd0, 1'b0, 19'h0,     1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      idle();
      ifc.state_fetch = 1'b1;
      case (i)
        0: begin ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_addr = 14'h0100; end
        1: begin ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_call = 1'b1; ifc.jump_addr = 14'h2000; end
        // Not-taken jump: call/ret bits must be ignored.
        2: begin ifc.jump_en = 1'b1; ifc.jcond = 1'b0; ifc.jump_call = 1'b1; ifc.jump_ret = 1'b1;
                 ifc.jump_addr = 14'h1234; end
        3: begin ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_ret = 1'b1; ifc.jump_addr = 14'h0777; end
        4: begin ifc.disp_en = 1'b1; ifc.disp_call = 1'b1; ifc.disp_addr = 14'h0300; end
        // call+ret together: return wins.
        default: begin ifc.disp_en = 1'b1; ifc.disp_call = 1'b1; ifc.disp_ret = 1'b1;
                       ifc.disp_addr = 14'h3ABC; end
      endcase
      q.push_back(exps[i]);
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL call_ret[%0d]: got %p want %p", i, o, e); end
    end
    // Dispatch outranks a taken jump; the jump's call is not performed.
    idle();
    ifc.state_fetch = 1'b1; ifc.disp_en = 1'b1; ifc.disp_addr = 14'h0400;
    ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_call = 1'b1; ifc.jump_addr = 14'h0500;
    q.push_back(mk(14'h0400, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL disp_prio: got %p want %p", o, e); end
  endtask

  task automatic test_wrap();
    idle();
    ifc.state_fetch = 1'b1; ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_addr = 14'h3FFF;
    q.push_back(mk(14'h3FFF, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL wrap_top: got %p want %p", o, e); end
    if (ifc.ipc !== 14'h0000) begin
      n_err++; $display("FAIL wrap_ipc0: got %h want 0000", ifc.ipc);
    end
    n_vec++;
    idle();
    ifc.state_fetch = 1'b1;
    q.push_back(mk(14'h0000, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e || ifc.ipc !== 14'h0001) begin
      n_err++; $display("FAIL wrap_seq: got %p want %p", o, e);
    end
  endtask

  task automatic test_trap();
    exp_t exps[5];
    exps[0] = mk(14'h0001, 5'd0, 1'b0, 19'h0,     1'b0, 1'b0, 1'b0);
    exps[1] = mk(14'h0600, 5'd1, 1'b0, 19'h00002, 1'b0, 1'b0, 1'b0);
    exps[2] = mk(14'h0000, 5'd1, 1'b1, 19'h00002, 1'b0, 1'b0, 1'b0);
    exps[3] = mk(14'h0000, 5'd1, 1'b1, 19'h00002, 1'b0, 1'b0, 1'b0);
    exps[4] = mk(14'h0001, 5'd1, 1'b0, 19'h00002, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      ifc.state_fetch = (i != 3);
      case (i)
        1: begin ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_call = 1'b1; ifc.jump_addr = 14'h0600; end
        2: begin ifc.trap = 1'b1; ifc.disp_en = 1'b1; ifc.disp_call = 1'b1; ifc.disp_addr = 14'h0AAA;
                 ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_ret = 1'b1; end
        default: ;
      endcase
      q.push_back(exps[i]);
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL trap[%0d]: got %p want %p", i, o, e); end
    end
  endtask

  task automatic test_overflow();
    logic [13:0] ra;
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // 33 dispatch calls; call i returns to 1 (i==1) or 0x1000+i.
    for (int i = 1; i <= 33; i++) begin
      idle();
      ifc.state_fetch = 1'b1; ifc.disp_en = 1'b1; ifc.disp_call = 1'b1;
      ifc.disp_addr = 14'(14'h1000 + i);
      ra = (i == 1) ? 14'h0001 : 14'(14'h1000 + i);
      q.push_back(mk(14'(14'h1000 + i), 5'(i), 1'b0, {5'd0, ra}, (i == 33), 1'b0, 1'b0));
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL ovf_call[%0d]: got %p want %p", i, o, e); end
    end
    // 33 returns: first yields call 33's address, the 33rd underflows.
    for (int j = 1; j <= 33; j++) begin
      logic [13:0] pc_x;
      logic [18:0] top_x;
      idle();
      ifc.state_fetch = 1'b1; ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_ret = 1'b1;
      ifc.jump_addr = 14'h2AAA;
      pc_x  = (j <= 32) ? 14'(14'h1000 + 34 - j) : 14'h0000;
      top_x = (j <= 31) ? {5'd0, 14'(14'h1000 + 33 - j)} : 19'h0;
      q.push_back(mk(pc_x, 5'(1 - j), 1'b0, top_x, 1'b1, (j == 33), 1'b0));
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL unf_pop[%0d]: got %p want %p", j, o, e); end
    end
  endtask

  task automatic test_conflict();
    exp_t exps[7];
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exps[0] = mk(14'h0200, 5'd1, 1'b0, 19'h00001, 1'b0, 1'b0, 1'b1);
    exps[1] = mk(14'h0200, 5'd2, 1'b0, 19'h12345, 1'b0, 1'b0, 1'b1);
    exps[2] = mk(14'h0200, 5'd3, 1'b0, 19'h54321, 1'b0, 1'b0, 1'b1);
    exps[3] = mk(14'h0200, 5'd2, 1'b0, 19'h12345, 1'b0, 1'b0, 1'b1);
    exps[4] = mk(14'h0201, 5'd1, 1'b0, 19'h00001, 1'b0, 1'b0, 1'b1);
    exps[5] = mk(14'h0001, 5'd0, 1'b0, 19'h0,     1'b0, 1'b0, 1'b1);
    exps[6] = mk(14'h0001, 5'd31, 1'b0, 19'h0,    1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin ifc.state_fetch = 1'b1; ifc.disp_en = 1'b1; ifc.disp_call = 1'b1;
                 ifc.disp_addr = 14'h0200; ifc.spc_wr = 1'b1; ifc.spc_wdata = 19'h7ABCD; end
        1: begin ifc.spc_wr = 1'b1; ifc.spc_wdata = 19'h12345; end
        2: begin ifc.spc_wr = 1'b1; ifc.spc_rd = 1'b1; ifc.spc_wdata = 19'h54321; end
        3: ifc.spc_rd = 1'b1;
        // Sequential fetch has no stack op, so the external pop proceeds.
        4: begin ifc.state_fetch = 1'b1; ifc.spc_rd = 1'b1; end
        5: begin ifc.state_fetch = 1'b1; ifc.jump_en = 1'b1; ifc.jcond = 1'b1; ifc.jump_ret = 1'b1; end
        default: ifc.spc_rd = 1'b1;
      endcase
      q.push_back(exps[i]);
      tick();
      e = q.pop_front(); o = observe(); n_vec++;
      if (o !== e) begin n_err++; $display("FAIL conflict[%0d]: got %p want %p", i, o, e); end
    end
    // Sticky flags clear only on reset.
    idle();
    reset = 1'b1;
    q.push_back(mk(14'h0, 5'd0, 1'b0, 19'h0, 1'b0, 1'b0, 1'b0));
    tick();
    reset = 1'b0;
    e = q.pop_front(); o = observe(); n_vec++;
    if (o !== e) begin n_err++; $display("FAIL sticky_clear: got %p want %p", o, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_seq();
    test_call_ret();
    test_wrap();
    test_trap();
    test_overflow();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npc_seq.md
Name: npc_seq

Overview:
- Microcode next-PC sequencer for the CADR4 control path.
- Each fetch it selects the next micro-PC from trap, dispatch, jump/call/return or sequential increment.
- Owns the 32-deep SPC (subroutine PC) return stack and generates `lpc_hold` for the last-PC register.
- Sits between the IR decode/condition logic and the control memory address mux.

Parameters:
- PC_W, 14, micro-PC width
- SPC_W, 19, SPC entry width; low PC_W bits are the return address, upper bits are opaque flags
- SPC_DEPTH, 32, stack entries (power of two)
- TRAP_VEC, 14'd0, micro-PC loaded on trap

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- state_fetch  in  1  advance strobe; every state update below occurs only on clk edges with state_fetch=1, except external SPC ops
- trap  in  1  force pc to TRAP_VEC
- disp_en  in  1  dispatch taken this fetch
- disp_addr  in  PC_W  dispatch target
- disp_call  in  1  dispatch also pushes return address
- disp_ret  in  1  dispatch is a return (target = stack top)
- jump_en  in  1  jump-class instruction
- jcond  in  1  jump condition result
- jump_addr  in  PC_W  jump target
- jump_call  in  1  taken jump pushes return address
- jump_ret  in  1  taken jump is a return
- spc_wr  in  1  external push (SPC write from M bus)
- spc_wdata  in  SPC_W  external push data
- spc_rd  in  1  external pop
- pc  out  PC_W  current micro-PC
- ipc  out  PC_W  pc+1, modulo 2^PC_W
- spc_top  out  SPC_W  stack top
- spcptr  out  5  stack pointer
- lpc_hold  out  1  inhibit last-PC capture
- spc_ovf  out  1  sticky overflow
- spc_unf  out  1  sticky underflow
- spc_conflict  out  1  sticky dropped external op

Behaviour:
- Reset values: pc=TRAP_VEC, spcptr=0, count=0, lpc_hold=0, all sticky flags 0. Reset overrides every other input that cycle; mid-operation reset discards pending ops. Stack RAM is not cleared.
- spc_top = mem[spcptr] when count>0, else 0.
- Next-PC priority, evaluated only on state_fetch=1:
  - trap → pc=TRAP_VEC, no stack op, lpc_hold←1.
  - disp_en → target = disp_ret ? spc_top[PC_W-1:0] : disp_addr.
  - jump_en & jcond → target = jump_ret ? spc_top[PC_W-1:0] : jump_addr.
  - Otherwise pc=ipc, including 14'h3FFF → 0.
  - lpc_hold←0 on every non-trap fetch, so it is high for exactly one fetch interval after a trap.
- Stack ops on a taken dispatch or jump:
  - call: push {zero-extended ipc}.
  - ret: pop.
  - call and ret both set: return wins, no push.
  - jump_en & ~jcond: no stack op even if call/ret are set.
- Push: spcptr←spcptr+1 (mod 32), then write mem[new ptr]. count saturates at SPC_DEPTH; a push at count==SPC_DEPTH overwrites the oldest entry and sets spc_ovf.
- Pop: spcptr←spcptr-1 (mod 32). count==0 → pc loads 0 (spc_top=0), ptr still decrements, count stays 0, spc_unf set.
- External ops, on any clock, not gated by state_fetch:
  - spc_wr pushes spc_wdata; spc_rd pops.
  - Same cycle as an internal stack op: the external op is dropped and spc_conflict set.
  - spc_wr and spc_rd together: push wins.
- Stack write is visible on spc_top the following cycle (1-cycle latency).
- Sticky flags clear only on reset.
- state_fetch=0: pc, lpc_hold and internal stack state hold.

Decomposition:
- Shared package (cadr_pkg): PC_W, SPC_W, SPC_DEPTH, TRAP_VEC, and an enum for next-PC source {SRC_TRAP, SRC_DISP, SRC_JUMP, SRC_SEQ}.
- One natural sub-module, spc_stack: circular stack RAM, pointer, count, overflow/underflow and the internal/external arbitration.
- npc_seq keeps the source mux and the pc/lpc_hold registers.

Test Plan:
- Reset, then 3 fetches with no control inputs → pc 0,1,2,3; lpc_hold=0; spcptr=0.
- pc=0x0100, jump_en=1, jcond=1, jump_call=1, jump_addr=0x2000 → pc=0x2000, spc_top=0x00101, spcptr=1. Next fetch jump_ret=1, jcond=1 → pc=0x0101, spcptr=0.
- pc=0x3FFF, sequential fetch → pc=0x0000, ipc=0x0001.
- trap=1, disp_en=1, jump_en=1 on the same fetch → pc=0, no stack change, lpc_hold=1. Next plain fetch → lpc_hold=0.
- 33 calls from reset → spc_ovf=1, spcptr=1; first pop returns the 33rd return address. Pop with count=0 → pc=0, spc_unf=1.
- spc_wr=1 with data 0x7ABCD while the same fetch performs disp_call → disp push occurs, external write dropped, spc_conflict=1.
